// File: rtl/ysyx_22050710_inst_sram.sv
// ysyx_22050710_inst_sram: fixed-latency instruction SRAM responder with a side preload port
module ysyx_22050710_inst_sram #(
  parameter int SRAM_ADDR_WD = 32,
  parameter int SRAM_DATA_WD = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int RD_LATENCY = 1,
  parameter logic [SRAM_DATA_WD-1:0] OOR_DATA = 32'h0000_0013
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inst_sram_en,
  input  logic [SRAM_ADDR_WD-1:0] i_inst_sram_addr,
  output logic [SRAM_DATA_WD-1:0] o_inst_sram_rdata,
  output logic                    o_inst_sram_rvalid,
  output logic                    o_inst_sram_err,
  input  logic                    i_load_we,
  input  logic [DEPTH_LOG2-1:0]   i_load_idx,
  input  logic [SRAM_DATA_WD-1:0] i_load_wdata
);
  if (RD_LATENCY < 1 || RD_LATENCY > 4 || SRAM_DATA_WD != 32) begin : g_bad_param
    $error("ysyx_22050710_inst_sram: RD_LATENCY must be 1..4 and SRAM_DATA_WD must be 32");
  end
  localparam logic [SRAM_ADDR_WD-1:0] SPAN = SRAM_ADDR_WD'(4) << DEPTH_LOG2;
  logic [SRAM_DATA_WD-1:0] mem [2**DEPTH_LOG2];
  logic [SRAM_ADDR_WD-1:0] off;
  logic                    bad;
  logic [SRAM_DATA_WD-1:0] word;
  logic [RD_LATENCY-1:0]   v;
  logic [RD_LATENCY-1:0]   e;
  logic [SRAM_DATA_WD-1:0] w [RD_LATENCY];
  assign off = i_inst_sram_addr - BASE_ADDR;
  assign bad = (i_inst_sram_addr[1:0] != 2'b00) || (off >= SPAN);
  assign word = bad ? OOR_DATA : mem[off[DEPTH_LOG2+1:2]];
  // preload port; not reset, so the loader may fill the array while the core is held in reset
  always_ff @(posedge i_clk) begin
    if (i_load_we) mem[i_load_idx] <= i_load_wdata;
  end
  // response pipeline; a word only advances with its valid so the last stage holds the last delivered word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v <= '0;
      e <= '0;
      for (int k = 0; k < RD_LATENCY; k++) w[k] <= '0;
    end else begin
      v[0] <= i_inst_sram_en;
      e[0] <= i_inst_sram_en & bad;
      if (i_inst_sram_en) w[0] <= word;
      for (int k = 1; k < RD_LATENCY; k++) begin
        v[k] <= v[k-1];
        e[k] <= e[k-1];
        if (v[k-1]) w[k] <= w[k-1];
      end
    end
  end
  assign o_inst_sram_rvalid = v[RD_LATENCY-1];
  assign o_inst_sram_err = e[RD_LATENCY-1];
  assign o_inst_sram_rdata = w[RD_LATENCY-1];
endmodule

// File: tb/tb_ysyx_22050710_inst_sram.sv
// tb_ysyx_22050710_inst_sram: checks latencies 1..3 side by side against a cycle-history memory model
module tb_ysyx_22050710_inst_sram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [11:0] lidx = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd [3];
  logic        rv [3];
  logic        er [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_22050710_inst_sram #(.RD_LATENCY(g + 1)) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_inst_sram_en(en),
      .i_inst_sram_addr(addr),
      .o_inst_sram_rdata(rd[g]),
      .o_inst_sram_rvalid(rv[g]),
      .o_inst_sram_err(er[g]),
      .i_load_we(we),
      .i_load_idx(lidx),
      .i_load_wdata(wdata)
    );
  end
  int nvec = 0;
  int nfail = 0;
  logic [31:0] mm [4096];
  bit          hv [16384];
  bit          herr [16384];
  logic [31:0] hd [16384];
  logic [31:0] last [3] = '{32'h0, 32'h0, 32'h0};
  int cyc = 0;
  int last_rst = -1;
  bit counting = 0;
  int cnt_en = 0;
  int cnt_rv [3] = '{0, 0, 0};
  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got v/e/data=%b/%b/%h want %b/%b/%h", name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask
  task automatic tick(input logic r, input logic e, input logic [31:0] a, input logic w, input logic [11:0] li, input logic [31:0] wd);
    logic [31:0] o;
    logic b;
    logic ev;
    logic ee;
    int j;
    rst = r; en = e; addr = a; we = w; lidx = li; wdata = wd;
    o = a - 32'h8000_0000;
    b = (a[1:0] != 2'b00) || (o >= 32'h0000_4000);
    hv[cyc] = e && !r;
    herr[cyc] = b;
    hd[cyc] = b ? 32'h0000_0013 : mm[o[13:2]];
    if (r) last_rst = cyc;
    if (counting && e && !r) cnt_en++;
    if (w) mm[li] = wd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      j = cyc - k;
      ev = (j >= 0) && (j > last_rst) && hv[j];
      ee = ev && herr[j];
      if (r) last[k] = 32'h0;
      else if (ev) last[k] = hd[j];
      if (counting && rv[k] === 1'b1) cnt_rv[k]++;
      chk($sformatf("model lat%0d cyc%0d", k + 1, cyc), {rv[k], er[k], rd[k]}, {ev, ee, last[k]});
    end
    cyc++;
  endtask
  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        we;
    logic [11:0] li;
    logic [31:0] wd;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl [11];
  initial begin
    logic [31:0] a;
    int sel;
    tbl[0]  = '{1'b1, 32'h8000_0000, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 32'h0000_0297};
    tbl[1]  = '{1'b1, 32'h8000_0004, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 32'h0000_8067};
    tbl[2]  = '{1'b1, 32'h8000_0002, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
    tbl[3]  = '{1'b1, 32'h8000_4000, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
    tbl[4]  = '{1'b1, 32'h7FFF_FFFC, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
    tbl[5]  = '{1'b1, 32'h8000_3FFC, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 32'hCAFE_0FFF};
    tbl[6]  = '{1'b1, 32'h8000_0014, 1'b1, 12'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h1111_1111};
    tbl[7]  = '{1'b1, 32'h8000_0014, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
    tbl[9]  = '{1'b1, 32'h0000_0000, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 32'h0000_0013};
    tbl[10] = '{1'b0, 32'h8000_0000, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 32'h0000_0013};
    for (int i = 0; i < 4096; i++)
      tick(1'b1, 1'b0, 32'h0, 1'b1, 12'(i),
           i == 0 ? 32'h0000_0297 : i == 1 ? 32'h0000_8067 : i == 5 ? 32'h1111_1111 :
           i == 4095 ? 32'hCAFE_0FFF : $urandom);
    for (int k = 0; k < 3; k++) chk($sformatf("reset lat%0d", k + 1), {rv[k], er[k], rd[k]}, 34'h0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, tbl[i].en, tbl[i].addr, tbl[i].we, tbl[i].li, tbl[i].wd);
      chk($sformatf("table%0d lat1", i), {rv[0], er[0], rd[0]}, {tbl[i].ev, tbl[i].ee, tbl[i].ed});
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    tick(1'b0, 1'b1, 32'h8000_0004, 1'b0, 12'd0, 32'h0);
    chk("lat3 edge0", {33'(rv[2]), 1'b0}, 34'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    chk("lat3 edge1", {33'(rv[2]), 1'b0}, 34'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    chk("lat3 edge2", {rv[2], er[2], rd[2]}, {1'b1, 1'b0, 32'h0000_8067});
    tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    chk("lat3 edge3", {33'(rv[2]), 1'b0}, 34'h0);
    tick(1'b0, 1'b1, 32'h8000_0000, 1'b0, 12'd0, 32'h0);
    chk("lat2 kill req0", {33'(rv[1]), 1'b0}, 34'h0);
    tick(1'b1, 1'b1, 32'h8000_0004, 1'b0, 12'd0, 32'h0);
    chk("lat2 kill rst", {rv[1], er[1], rd[1]}, 34'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
      chk($sformatf("lat2 post-rst idle%0d", i), {rv[1], er[1], rd[1]}, 34'h0);
    end
    tick(1'b0, 1'b1, 32'h8000_0004, 1'b0, 12'd0, 32'h0);
    chk("lat2 new req edge0", {rv[1], er[1], rd[1]}, 34'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    chk("lat2 new req edge1", {rv[1], er[1], rd[1]}, {1'b1, 1'b0, 32'h0000_8067});
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    counting = 1;
    for (int i = 0; i < 10000; i++) begin
      sel = $urandom_range(0, 9);
      a = 32'h8000_0000 + ({20'b0, 12'($urandom)} << 2);
      if (sel == 7) a = 32'h8000_3FFC + 32'($urandom_range(0, 1) * 4);
      else if (sel == 8) a[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 9) a = $urandom;
      tick(1'b0, 1'($urandom_range(0, 1)), a, $urandom_range(0, 4) == 0, 12'($urandom), $urandom);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 12'd0, 32'h0);
    counting = 0;
    for (int k = 0; k < 3; k++) chk($sformatf("rvalid count lat%0d", k + 1), 34'(cnt_rv[k]), 34'(cnt_en));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
